// File: rtl/key_pkg.sv
// Shared types and default timing constants for the key conditioning block.
package key_pkg;

    // Per-key hold tracking: idle, held (waiting for long press), long (auto-repeating).
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HELD = 2'd1,
        S_LONG = 2'd2
    } key_state_e;

    // Defaults for a 50 MHz system clock.
    localparam int unsigned KEY_DEB_10MS  = 500000;
    localparam int unsigned KEY_LONG_1S   = 50000000;
    localparam int unsigned KEY_REP_200MS = 10000000;

    // Counter width able to hold 0..max; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key channel: 2-flop synchronizer, debounce counter, hold/repeat FSM
// and registered 1-cycle event pulses. Raw key is active-low.
//
// Handshake: none. Every output is a registered level or a pulse that is
// high for exactly one clock; consumers sample it on any clock edge.
module key_debounce_channel
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = KEY_DEB_10MS,
    parameter int unsigned LONG_CYCLES     = KEY_LONG_1S,
    parameter int unsigned REPEAT_CYCLES   = KEY_REP_200MS
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat
);

    localparam int unsigned DEB_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = cnt_width(LONG_CYCLES);
    localparam int unsigned REP_W  = cnt_width(REPEAT_CYCLES);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  =
        (REPEAT_CYCLES == 0) ? '0 : REP_W'(REPEAT_CYCLES - 1);

    // Synchronizer keeps raw polarity (1 = released) so reset means "released".
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              deb_level_q, deb_level_d;   // accepted level, 1 = pressed
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    key_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;
    logic              synced_pressed;

    // Synchronizer and debounce: accept a new level only after it has differed
    // from the accepted level for DEBOUNCE_CYCLES consecutive edges.
    always_comb begin
        sync1_d        = i_key;
        sync2_d        = sync1_q;
        synced_pressed = ~sync2_q;
        deb_level_d    = deb_level_q;
        deb_cnt_d      = '0;
        if (synced_pressed != deb_level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_level_d = synced_pressed;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // Hold FSM: press -> long press -> periodic repeat; release always wins.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (deb_level_q) begin
                    state_d    = S_HELD;
                    press_d    = 1'b1;
                    level_d    = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            S_HELD: begin
                if (!deb_level_q) begin
                    state_d   = S_IDLE;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d   = S_LONG;
                    long_d    = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            S_LONG: begin
                if (!deb_level_q) begin
                    state_d   = S_IDLE;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else if (REPEAT_CYCLES != 0) begin
                    if (rep_cnt_q == REP_LAST) begin
                        repeat_d  = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                level_d = 1'b0;
            end
        endcase
    end

    // All channel state, with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            deb_level_q <= 1'b0;
            deb_cnt_q   <= '0;
            state_q     <= S_IDLE;
            hold_cnt_q  <= '0;
            rep_cnt_q   <= '0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_level_q <= deb_level_d;
            deb_cnt_q   <= deb_cnt_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_long    = long_q;
    assign o_repeat  = repeat_q;

endmodule

// File: rtl/key_debounce_pulser.sv
// Conditions raw active-low push-buttons into clean per-key events.
// Channels are fully independent; the top only replicates them.
module key_debounce_pulser
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS          = 3,
    parameter int unsigned DEBOUNCE_CYCLES = KEY_DEB_10MS,
    parameter int unsigned LONG_CYCLES     = KEY_LONG_1S,
    parameter int unsigned REPEAT_CYCLES   = KEY_REP_200MS
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_KEYS-1:0] i_key,
    output logic [N_KEYS-1:0] o_level,
    output logic [N_KEYS-1:0] o_press,
    output logic [N_KEYS-1:0] o_release,
    output logic [N_KEYS-1:0] o_long,
    output logic [N_KEYS-1:0] o_repeat
);

    // One independent channel per key.
    for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_chan (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_key     (i_key[g]),
            .o_level   (o_level[g]),
            .o_press   (o_press[g]),
            .o_release (o_release[g]),
            .o_long    (o_long[g]),
            .o_repeat  (o_repeat[g])
        );
    end

endmodule

// File: tb/tb_key_debounce_pulser.sv
// Directed bench for key_debounce_pulser with short timing constants.
// Edge numbers count posedges after reset deasserts (first active edge = 1).
module tb_key_debounce_pulser;

    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int REP = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] key;
    logic [2:0] level, press, rel, lng, rpt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    key_debounce_pulser #(
        .N_KEYS          (3),
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LNG),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_key     (key),
        .o_level   (level),
        .o_press   (press),
        .o_release (rel),
        .o_long    (lng),
        .o_repeat  (rpt)
    );

    // Clock
    always #5 clk = ~clk;

    // One case: keys in 'mask' go low for 'low_len' edges from 'low_from'
    // (optionally bouncing in 3-edge segments); expected event edges for
    // those keys are listed, -1 = never. Other keys must stay silent.
    typedef struct {
        string      name;
        logic [2:0] mask;
        int         low_from;
        int         low_len;
        bit         bounce;
        int         n_cyc;
        int         press_at;
        int         rel_at;
        int         long_at;
        int         rep_a;
        int         rep_b;
    } case_t;

    case_t cases[5];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s edge=%0d actual=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".level"},   level, 3'b000);
        check({tag, ".press"},   press, 3'b000);
        check({tag, ".release"}, rel,   3'b000);
        check({tag, ".long"},    lng,   3'b000);
        check({tag, ".repeat"},  rpt,   3'b000);
    endtask

    task automatic do_reset(input int n_edges);
        rst_n = 1'b0;
        key   = 3'b111;
        for (int i = 0; i < n_edges; i++) begin
            step();
            check_all_zero("reset");
        end
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic run_case(input case_t c);
        logic [2:0] e_level, e_press, e_rel, e_long, e_rep;
        bit         low;
        bit         lvl;
        do_reset(3);
        for (int t = 1; t <= c.n_cyc; t++) begin
            low = (c.low_from >= 0) && (t >= c.low_from) && (t < c.low_from + c.low_len);
            if (low && c.bounce && (((t - c.low_from) / 3) % 2 == 1)) low = 1'b0;
            key = low ? ~c.mask : 3'b111;
            step();
            lvl = (c.press_at >= 0) && (cyc >= c.press_at) &&
                  ((c.rel_at < 0) || (cyc < c.rel_at));
            e_level = lvl ? c.mask : 3'b000;
            e_press = (cyc == c.press_at) ? c.mask : 3'b000;
            e_rel   = (cyc == c.rel_at)   ? c.mask : 3'b000;
            e_long  = (cyc == c.long_at)  ? c.mask : 3'b000;
            e_rep   = ((cyc == c.rep_a) || (cyc == c.rep_b)) ? c.mask : 3'b000;
            check({c.name, ".level"},   level, e_level);
            check({c.name, ".press"},   press, e_press);
            check({c.name, ".release"}, rel,   e_rel);
            check({c.name, ".long"},    lng,   e_long);
            check({c.name, ".repeat"},  rpt,   e_rep);
        end
        key = 3'b111;
    endtask

    // Key 0 held into the long/repeat phase, then reset while still held.
    task automatic reset_while_held();
        int n_long;
        n_long = 0;
        do_reset(3);
        for (int t = 1; t <= 40; t++) begin
            key = (t >= 10) ? 3'b110 : 3'b111;
            step();
            if (lng[0]) n_long++;
            check("rsth.press", press, (cyc == 16) ? 3'b001 : 3'b000);
            check("rsth.long",  lng,   (cyc == 36) ? 3'b001 : 3'b000);
        end
        check("rsth.long_count", 3'(n_long), 3'd1);
        // Reset for two edges with the key still down.
        rst_n = 1'b0;
        step();
        check_all_zero("rsth.in_reset1");
        step();
        check_all_zero("rsth.in_reset2");
        rst_n = 1'b1;
        // Edge 43 is the first active edge; fresh press expected DEB+2 later.
        for (int t = 43; t <= 55; t++) begin
            step();
            check("rsth.release", rel,   3'b000);
            check("rsth.repress", press, (cyc == 43 + DEB + 2) ? 3'b001 : 3'b000);
            check("rsth.level",   level, (cyc >= 43 + DEB + 2) ? 3'b001 : 3'b000);
        end
        key = 3'b111;
    endtask

    initial begin
        rst_n = 1'b0;
        key   = 3'b111;

        cases[0] = '{"idle",   3'b000, -1,  0, 1'b0, 100, -1, -1, -1, -1, -1};
        cases[1] = '{"short",  3'b001, 10, 12, 1'b0,  40, 16, 28, -1, -1, -1};
        cases[2] = '{"bounce", 3'b010, 10, 30, 1'b1,  50, -1, -1, -1, -1, -1};
        cases[3] = '{"hold",   3'b100, 10, 40, 1'b0,  64, 16, 56, 36, 44, 52};
        cases[4] = '{"simul",  3'b101, 10, 12, 1'b0,  40, 16, 28, -1, -1, -1};

        for (int i = 0; i < 5; i++) begin
            run_case(cases[i]);
        end

        reset_while_held();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
